// File: rtl/dual_rail_tx_buffer.sv
// dual_rail_tx_buffer: clocked FIFO feeding a dual-rail (TP/FP) async link.
// Define DUAL_RAIL_TX_TIMEOUT_EN to build the sticky ack watchdog.
module dual_rail_tx_buffer #(
    parameter ENC = "TP",
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int SYNC_STAGES = 2,
    localparam int RAIL_NUM = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [WIDTH-1:0]                   in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [WIDTH-1:0][RAIL_NUM-1:0]     out,
    input  logic                               ack,
    output logic                               busy,
    output logic [AW:0]                        count,
    output logic                               timeout
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WAIT_HI,
        WAIT_LO
    } state_t;

    localparam bit IS_FP = (ENC == "FP");
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    if ((ENC != "TP") && (ENC != "FP")) begin : g_bad_enc
        $error("dual_rail_tx_buffer: ENC must be TP or FP");
    end

    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("dual_rail_tx_buffer: DEPTH must be a power of two >= 2");
    end

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("dual_rail_tx_buffer: SYNC_STAGES must be >= 2");
    end

    logic [WIDTH-1:0]             mem [DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic                         push;
    logic                         pop;
    logic [WIDTH-1:0]             head;

    logic [SYNC_STAGES-1:0]       ack_sync;
    logic                         ack_s;

    state_t                       state;
    state_t                       state_d;
    logic                         exp_q;
    logic                         exp_d;
    logic [WIDTH-1:0][RAIL_NUM-1:0] out_d;

    // A full FIFO refuses the push even when a pop happens this cycle.
    assign in_ready = (count != FULL_CNT);
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign ack_s    = ack_sync[SYNC_STAGES-1];
    assign busy     = (state != IDLE);

    // FIFO storage; data needs no reset, only the pointers do.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Bring the asynchronous acknowledge into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
        end
    end

    // Handshake state, expected ack phase and the registered rails.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            exp_q <= 1'b0;
            out   <= '0;
        end else begin
            state <= state_d;
            exp_q <= exp_d;
            out   <= out_d;
        end
    end

    // Next-state logic: launch from IDLE, then wait on the synced ack.
    always_comb begin
        state_d = state;
        exp_d   = exp_q;
        out_d   = out;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (IS_FP) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            out_d[i] = {head[i], ~head[i]};
                        end
                        state_d = WAIT_HI;
                    end else begin
                        for (int i = 0; i < WIDTH; i++) begin
                            out_d[i][1] = out[i][1] ^ head[i];
                            out_d[i][0] = out[i][0] ^ ~head[i];
                        end
                        exp_d   = ~exp_q;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (ack_s == exp_q) begin
                    state_d = IDLE;
                end
            end
            WAIT_HI: begin
                if (ack_s) begin
                    out_d   = '0;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef DUAL_RAIL_TX_TIMEOUT_EN
    logic [9:0] wd_cnt;
    logic [9:0] wd_cnt_d;
    logic       timeout_q;

    // Watchdog count: cleared on any state change, saturates at 1023.
    always_comb begin
        wd_cnt_d = wd_cnt;
        if (state_d != state) begin
            wd_cnt_d = '0;
        end else if ((state != IDLE) && (wd_cnt != 10'h3ff)) begin
            wd_cnt_d = wd_cnt + 1'b1;
        end
    end

    // Watchdog register and sticky flag; only reset clears the flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_d;
            if (wd_cnt_d == 10'h3ff) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dual_rail_tx_buffer.sv
// tb_dual_rail_tx_buffer: directed checks of the TP and FP transmitters.
// Build with +define+DUAL_RAIL_TX_TIMEOUT_EN to cover the watchdog.
module tb_dual_rail_tx_buffer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [3:0]      in_data_tp = '0;
    logic            in_valid_tp = 1'b0;
    logic            in_ready_tp;
    logic [3:0][1:0] out_tp;
    logic            ack_tp;
    logic            busy_tp;
    logic [2:0]      count_tp;
    logic            timeout_tp;

    logic [1:0]      in_data_fp = '0;
    logic            in_valid_fp = 1'b0;
    logic            in_ready_fp;
    logic [1:0][1:0] out_fp;
    logic            ack_fp = 1'b0;
    logic            busy_fp;
    logic [2:0]      count_fp;
    logic            timeout_fp;

    logic            loop_en = 1'b0;
    logic            ack_man = 1'b0;
    logic [2:0]      pipe = '0;
    logic [3:0][1:0] prev_out = '0;
    logic            busy_prev = 1'b0;
    int              busy_rises = 0;
    logic [3:0]      got_q[$];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign ack_tp = loop_en ? pipe[2] : ack_man;

    dual_rail_tx_buffer #(
        .ENC("TP"), .WIDTH(4), .DEPTH(4), .SYNC_STAGES(2)
    ) u_tp (
        .clk(clk), .rst(rst),
        .in_data(in_data_tp), .in_valid(in_valid_tp),
        .in_ready(in_ready_tp), .out(out_tp), .ack(ack_tp),
        .busy(busy_tp), .count(count_tp), .timeout(timeout_tp)
    );

    dual_rail_tx_buffer #(
        .ENC("FP"), .WIDTH(2), .DEPTH(4), .SYNC_STAGES(2)
    ) u_fp (
        .clk(clk), .rst(rst),
        .in_data(in_data_fp), .in_valid(in_valid_fp),
        .in_ready(in_ready_fp), .out(out_fp), .ack(ack_fp),
        .busy(busy_fp), .count(count_fp), .timeout(timeout_fp)
    );

    // Receiver model for the TP link plus a token/busy monitor.
    always begin
        @(posedge clk);
        #2;
        if (!rst) begin
            pipe = '0;
            prev_out = '0;
            busy_prev = 1'b0;
        end else begin
            pipe = {pipe[1:0], out_tp[0][1] ^ out_tp[0][0]};
            if (out_tp != prev_out) begin
                logic [3:0] w;
                for (int i = 0; i < 4; i++) begin
                    w[i] = out_tp[i][1] ^ prev_out[i][1];
                end
                got_q.push_back(w);
                prev_out = out_tp;
            end
            if (busy_tp && !busy_prev) begin
                busy_rises++;
            end
            busy_prev = busy_tp;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Caller sits on a negedge; the word is pushed at the next posedge.
    task automatic push_tp(input logic [3:0] d);
        in_valid_tp = 1'b1;
        in_data_tp = d;
        @(negedge clk);
        in_valid_tp = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy_tp || count_tp != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 200), 1);
    endtask

    task automatic chk_words(input string tag, input logic [3:0] w[6],
                             input int n);
        chk({tag, "_n"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            chk(tag, (i < got_q.size()) ? got_q[i] : 4'hx, w[i]);
        end
    endtask

    initial begin
        logic [3:0] wv[6];

        repeat (3) @(negedge clk);
        chk("rst_out", out_tp, 0);
        chk("rst_busy", busy_tp, 0);
        chk("rst_count", count_tp, 0);
        chk("rst_ready", in_ready_tp, 1);
        chk("rst_tmo", timeout_tp, 0);
        chk("rst_fp_out", out_fp, 0);
        chk("rst_fp_ready", in_ready_fp, 1);
        chk("rst_fp_tmo", timeout_fp, 0);
        rst = 1'b1;
        @(negedge clk);

        // TP with ack looped back after 3 cycles.
        loop_en = 1'b1;
        push_tp(4'hA);
        @(negedge clk);
        chk("tp_a_out", out_tp, 8'h99);
        chk("tp_a_busy", busy_tp, 1);
        wait_idle("tp_a_idle");
        push_tp(4'h5);
        @(negedge clk);
        chk("tp_5_out", out_tp, 8'hFF);
        wait_idle("tp_5_idle");
        wv = '{4'hA, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0};
        chk_words("tp_order", wv, 2);
        chk("tp_busy_pulses", busy_rises, 2);

        // FP single token.
        in_valid_fp = 1'b1;
        in_data_fp = 2'b10;
        @(negedge clk);
        in_valid_fp = 1'b0;
        @(negedge clk);
        chk("fp_data", out_fp, 4'h9);
        chk("fp_busy", busy_fp, 1);
        repeat (3) @(negedge clk);
        chk("fp_hold", out_fp, 4'h9);
        ack_fp = 1'b1;
        repeat (2) @(negedge clk);
        chk("fp_pre_spacer", out_fp, 4'h9);
        @(negedge clk);
        chk("fp_spacer", out_fp, 4'h0);
        repeat (3) @(negedge clk);
        chk("fp_wait_lo", busy_fp, 1);
        ack_fp = 1'b0;
        repeat (2) @(negedge clk);
        chk("fp_lo_busy", busy_fp, 1);
        @(negedge clk);
        chk("fp_idle", busy_fp, 0);
        chk("fp_count", count_fp, 0);

        // Fill the FIFO with ack held low, then drain.
        loop_en = 1'b0;
        ack_man = 1'b0;
        got_q.delete();
        busy_rises = 0;
        wv = '{4'h3, 4'hC, 4'h7, 4'h8, 4'hE, 4'h1};
        for (int k = 0; k < 5; k++) begin
            in_valid_tp = 1'b1;
            in_data_tp = wv[k];
            @(negedge clk);
        end
        in_data_tp = wv[5];
        chk("full_count", count_tp, 4);
        chk("full_ready", in_ready_tp, 0);
        chk("full_first", out_tp, 8'hA5);
        repeat (2) @(negedge clk);
        chk("full_stall", count_tp, 4);
        ack_man = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_idle", busy_tp, 0);
        chk("full_idle_ready", in_ready_tp, 0);
        @(negedge clk);
        chk("full_pushpop", count_tp, 3);
        chk("full_relaunch", busy_tp, 1);
        @(negedge clk);
        chk("full_late_push", count_tp, 4);
        in_valid_tp = 1'b0;
        loop_en = 1'b1;
        wait_idle("full_drain");
        chk_words("full_order", wv, 6);
        chk("full_busy_pulses", busy_rises, 6);

        // Reset in the middle of a TP token.
        @(negedge clk);
        loop_en = 1'b0;
        ack_man = 1'b0;
        push_tp(4'h6);
        push_tp(4'hB);
        chk("mid_busy", busy_tp, 1);
        chk("mid_count", count_tp, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_out", out_tp, 0);
        chk("mid_rst_count", count_tp, 0);
        chk("mid_rst_busy", busy_tp, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_tp(4'h9);
        @(negedge clk);
        chk("post_rst_out", out_tp, 8'h96);
        ack_man = 1'b1;
        wait_idle("post_rst_idle");

`ifdef DUAL_RAIL_TX_TIMEOUT_EN
        push_tp(4'h2);
        @(negedge clk);
        repeat (1022) @(negedge clk);
        chk("tmo_early", timeout_tp, 0);
        @(negedge clk);
        chk("tmo_set", timeout_tp, 1);
        chk("tmo_still_busy", busy_tp, 1);
        ack_man = 1'b0;
        wait_idle("tmo_idle");
        chk("tmo_sticky", timeout_tp, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("tmo_cleared", timeout_tp, 0);
        rst = 1'b1;
        @(negedge clk);
`else
        push_tp(4'h2);
        repeat (10) @(negedge clk);
        chk("tmo_off", timeout_tp, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
